delay_pe: RTL and testbench
===========================

# delay_pe

Parametrised, runtime-programmable delay processing element: stub PE for systolic-array bring-up and latency matching. Carries NUM_CH channels of DATA_W-bit data plus a valid tag through a circular buffer. Delay is set per-run through a load strobe, and the pipeline can be stalled with a clock enable. Sits in the PE array wherever a real compute PE is not yet available, so that array-level dataflow and latency can be exercised.

## Interface
- NUM_CH, 2, number of parallel data channels
- DATA_W, 4, bits per channel
- MAX_DELAY, 16, largest supported delay in enabled cycles (≥2)
- DEFAULT_DELAY, 10, delay in force after reset (1..MAX_DELAY)
- DLY_W, $clog2(MAX_DELAY+1), derived width of delay fields; not to be overridden
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- en  in  1  advance enable; 0 = stall, all state held
- cfg_load  in  1  single-cycle strobe: latch cfg_delay and flush
- cfg_delay  in  DLY_W  requested delay
- in_valid  in  1  input sample valid
- in_data  in  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- out_valid  out  1  delayed valid
- out_data  out  NUM_CH*DATA_W  delayed data, same packing
- busy  out  1  refilling after a delay change

## Operation
- Storage: circular buffer of MAX_DELAY entries of {valid, data}, plus a write pointer. The pointer wraps from MAX_DELAY-1 to 0. Read index = (wptr − D + 1) mod MAX_DELAY.
- Delay D: a sample accepted on enabled edge k appears on out_* right after enabled edge k+D−1. D=1 therefore behaves as a single register.
- en=0: no pointer move, no write, no FSM or counter change; out_* and busy hold their values.
- Accept: on an enabled edge, {in_valid, in_data} is written. When in_valid=0, a bubble propagates.
- out_data is driven to 0 whenever out_valid is 0.
- cfg_load is honoured regardless of en:
  - D ← clamp(cfg_delay): 0 becomes 1, values above MAX_DELAY become MAX_DELAY.
  - All stored valid bits clear on the same edge, so out_valid=0 after that edge.
  - FSM goes to FILL with fill_cnt=0.
  - An enabled sample presented on the load edge is kept, with its valid bit, and is subject to the new D.
- FSM states:
  - RUN (reset state): busy=0. cfg_load → FILL.
  - FILL: busy=1. Each enabled edge increments fill_cnt. When fill_cnt reaches D−1 on an enabled edge → RUN. A cfg_load during FILL restarts FILL with the new D.
- Reset values: all stored valid bits 0, wptr=0, D=DEFAULT_DELAY, state RUN, out_valid=0, out_data=0, busy=0.

## Timing
- Latency: D enabled clocks, input pins to output pins; all outputs registered. Stall cycles add one cycle each.
- Throughput: one sample per enabled clock, with no bubbles inserted.
- busy falls on the same edge the sample accepted at the load edge emerges.
- Reset mid-stream:
  - All in-flight samples are discarded.
  - The delay reverts to DEFAULT_DELAY, not the last loaded value.
  - The first sample after reset deassertion emerges D enabled edges later.
- No combinational path from any input to any output.

## Structure
- Package delay_pe_pkg holds:
  - the clamp function for delay values
  - the DLY_W derivation
  - the FSM state encoding (RUN, FILL)
- Sub-module delay_pe_buf implements the circular buffer: pointer, write port, read port at offset, and synchronous bulk valid-clear. The top level holds the delay register, the FSM/fill counter and the output register.

## Test plan
- Reset, defaults: release rstn, drive a ramp in_data 0x01,0x02,… with in_valid=1 → first out_valid at the 10th edge, out_data=0x01; then one sample per clock in order.
- Stall: D=4, stream 0x11..0x18, drop en for 3 cycles mid-stream → outputs freeze for 3 cycles, no sample lost or duplicated, total latency 7 clocks for stalled samples.
- Reload: while streaming at D=10, pulse cfg_load with cfg_delay=3 → out_valid=0 the next cycle, busy high exactly 2 enabled cycles, load-edge sample emerges 3 enabled edges later.
- Clamp/bounds: cfg_delay=0 → D=1, output one cycle after input. cfg_delay=31 (MAX_DELAY=16) → D=16. Wrap verified by streaming more than 40 samples.
- Bubbles and channels: NUM_CH=4, DATA_W=8, alternate in_valid 1/0 → out_valid pattern identical and delayed; out_data=0 on bubble cycles; channel lanes not swapped.
- Async reset mid-FILL: assert rstn low between clock edges → outputs 0 immediately; after release, D=DEFAULT_DELAY, busy=0.

Source files
------------

// File: rtl/delay_pe_pkg.sv
// Shared types and helpers for the delay PE: FSM encoding, delay-field width, delay clamp.
// Pure declarations; no logic, latency or flow control of its own.
package delay_pe_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  function automatic int dly_width(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

  function automatic int clamp_delay(input int req, input int max_delay);
    if (req < 1) return 1;
    if (req > max_delay) return max_delay;
    return req;
  endfunction

endpackage

// File: rtl/delay_pe_buf.sv
// Circular {valid, data} store with write pointer, offset read port and bulk valid clear.
// Read is combinational from storage; no backpressure, en=0 freezes pointer and contents.
module delay_pe_buf import delay_pe_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int DLY_W = dly_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic             wr_vld,
  input  logic [W-1:0]     wr_dat,
  input  logic [DLY_W-1:0] rd_dly,
  output logic             rd_vld,
  output logic [W-1:0]     rd_dat
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rd_off, rd_idx;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [W-1:0]     dat_q [DEPTH];
  logic [W-1:0]     dat_d [DEPTH];

  always_comb begin
    wptr_d = wptr_q;
    vld_d  = vld_q;
    dat_d  = dat_q;
    if (clr) vld_d = '0;
    // the write lands after the clear so a sample taken on the flush edge survives
    if (en) begin
      vld_d[wptr_q] = wr_vld;
      dat_d[wptr_q] = wr_dat;
      wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
    end
  end

  always_comb begin
    rd_off = PTR_W'(rd_dly - DLY_W'(1));
    rd_idx = wptr_q - rd_off + ((wptr_q < rd_off) ? PTR_W'(DEPTH) : '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      vld_q  <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      vld_q  <= vld_d;
      dat_q  <= dat_d;
    end
  end

  assign rd_vld = vld_q[rd_idx];
  assign rd_dat = dat_q[rd_idx];

endmodule

// File: rtl/delay_pe.sv
// Runtime-programmable delay PE: NUM_CH lanes plus valid delayed by D enabled clocks (1..MAX_DELAY).
// Latency D enabled clocks, registered outputs; no backpressure, en=0 stalls everything, cfg_load flushes.
module delay_pe import delay_pe_pkg::*; #(
  parameter int NUM_CH        = 2,
  parameter int DATA_W        = 4,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 10,
  parameter int DLY_W         = dly_width(MAX_DELAY)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic                     cfg_load,
  input  logic [DLY_W-1:0]         cfg_delay,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     busy
);

  localparam int W = NUM_CH * DATA_W;

  state_t           state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d, dly_new;
  logic [DLY_W-1:0] fill_q, fill_d;
  logic             out_vld_q, out_vld_d;
  logic [W-1:0]     out_dat_q, out_dat_d;
  logic             src_vld, rd_vld;
  logic [W-1:0]     src_dat, rd_dat;

  delay_pe_buf #(
    .DEPTH (MAX_DELAY),
    .W     (W),
    .DLY_W (DLY_W)
  ) u_buf (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .clr    (cfg_load),
    .wr_vld (in_valid),
    .wr_dat (in_data),
    .rd_dly (dly_q),
    .rd_vld (rd_vld),
    .rd_dat (rd_dat)
  );

  always_comb begin
    dly_new = DLY_W'(clamp_delay(int'(cfg_delay), MAX_DELAY));
    dly_d   = cfg_load ? dly_new : dly_q;

    // D=1 is a plain register: the sample being written goes straight to the output
    if (dly_d == DLY_W'(1)) begin
      src_vld = in_valid;
      src_dat = in_data;
    end else begin
      src_vld = rd_vld & ~cfg_load;
      src_dat = rd_dat;
    end

    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    if (en) begin
      out_vld_d = src_vld;
      out_dat_d = src_vld ? src_dat : '0;
    end else if (cfg_load) begin
      out_vld_d = 1'b0;
      out_dat_d = '0;
    end

    state_d = state_q;
    fill_d  = fill_q;
    if (cfg_load) begin
      state_d = ST_FILL;
      fill_d  = '0;
    end else if (en && state_q == ST_FILL) begin
      fill_d = fill_q + DLY_W'(1);
      if (fill_d >= dly_q - DLY_W'(1)) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_RUN;
      dly_q     <= DLY_W'(DEFAULT_DELAY);
      fill_q    <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      fill_q    <= fill_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign busy      = (state_q == ST_FILL);

endmodule

// File: tb/tb_delay_pe.sv
// Bench for delay_pe (4 lanes x 8 bits): directed corner sequences, a clamp table,
// then randomized traffic against a history-array reference model.
module tb_delay_pe;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_DELAY = 16;
  localparam int DEF_DLY   = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        cfg_load = 1'b0;
  logic [4:0]  cfg_delay = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        busy;

  always #5 clk = ~clk;

  delay_pe #(
    .NUM_CH        (NUM_CH),
    .DATA_W        (DATA_W),
    .MAX_DELAY     (MAX_DELAY),
    .DEFAULT_DELAY (DEF_DLY)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .cfg_load  (cfg_load),
    .cfg_delay (cfg_delay),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  int nchk = 0;
  int nerr = 0;

  // Reference: every accepted sample indexed by its enabled-edge number.
  bit          hist_v [0:4095];
  logic [31:0] hist_d [0:4095];
  int          ecnt = 0;
  int          flush_e = 0;
  int          m_d = DEF_DLY;
  int          busy_left = 0;
  int          cyc = 0;
  logic        m_vld = 1'b0;
  logic [31:0] m_dat = '0;

  int acc [8];
  int emg [8];
  int nv;

  typedef struct {
    logic [4:0] cfg;
    int         exp_lat;
  } clamp_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_ref(input int c);
    if (c == 0) return 1;
    if (c > MAX_DELAY) return MAX_DELAY;
    return c;
  endfunction

  task automatic model_reset();
    m_d       = DEF_DLY;
    flush_e   = ecnt;
    busy_left = 0;
    m_vld     = 1'b0;
    m_dat     = '0;
  endtask

  task automatic model_out(input int n);
    int idx;
    idx = n - m_d + 1;
    if (idx >= flush_e && hist_v[idx]) begin
      m_vld = 1'b1;
      m_dat = hist_d[idx];
    end else begin
      m_vld = 1'b0;
      m_dat = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rstn) begin
      if (cfg_load) begin
        m_d       = clamp_ref(int'(cfg_delay));
        busy_left = (m_d > 1) ? m_d - 1 : 1;
        flush_e   = ecnt;
        if (en) begin
          hist_v[ecnt] = in_valid;
          hist_d[ecnt] = in_data;
          model_out(ecnt);
          ecnt++;
        end else begin
          m_vld = 1'b0;
          m_dat = '0;
        end
      end else if (en) begin
        hist_v[ecnt] = in_valid;
        hist_d[ecnt] = in_data;
        model_out(ecnt);
        ecnt++;
        if (busy_left > 0) busy_left--;
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    chk("out_data", out_data, m_dat);
    chk("busy", 32'(busy), 32'(busy_left > 0));
  endtask

  task automatic note_emerge();
    int b;
    if (out_valid && en) begin
      nv++;
      b = int'(out_data[7:0]) - 'h11;
      if (b >= 0 && b < 8 && emg[b] < 0) emg[b] = cyc;
    end
  endtask

  function automatic logic [31:0] lanes(input int v);
    return {8'(v + 'h30), 8'(v + 'h20), 8'(v + 'h10), 8'(v)};
  endfunction

  initial begin
    clamp_vec_t tbl [8];
    int first, s, nb, em, lat;

    tbl[0] = '{5'd0,  1};
    tbl[1] = '{5'd1,  1};
    tbl[2] = '{5'd2,  2};
    tbl[3] = '{5'd3,  3};
    tbl[4] = '{5'd16, 16};
    tbl[5] = '{5'd17, 16};
    tbl[6] = '{5'd31, 16};
    tbl[7] = '{5'd10, 10};

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();

    // Default delay with a ramp
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    en = 1'b1;
    first = -1;
    for (int i = 1; i <= 14; i++) begin
      in_valid = 1'b1;
      in_data  = lanes(i);
      step();
      if (out_valid && first < 0) begin
        first = i;
        chk("ramp_first_data", 32'(out_data[7:0]), 32'h01);
      end
    end
    chk("ramp_first_edge", 32'(first), 32'd10);

    // Stall at D=4
    cfg_load = 1'b1; cfg_delay = 5'd4; in_valid = 1'b0;
    step();
    cfg_load = 1'b0;
    repeat (6) step();
    for (int k = 0; k < 8; k++) begin acc[k] = -1; emg[k] = -1; end
    s = 0; nv = 0;
    for (int i = 0; i < 11; i++) begin
      if (i >= 4 && i <= 6) begin
        en = 1'b0; in_valid = 1'b1; in_data = 32'hEEEEEEEE;
      end else begin
        en = 1'b1; in_valid = 1'b1;
        in_data = {8'(s + 'hD1), 8'(s + 'hC1), 8'(s + 'hB1), 8'(s + 'h11)};
        acc[s] = cyc + 1;
        s++;
      end
      step();
      note_emerge();
    end
    en = 1'b1; in_valid = 1'b0;
    repeat (6) begin step(); note_emerge(); end
    chk("stall_lat_0x11", 32'(emg[0] - acc[0] + 1), 32'd4);
    chk("stall_lat_0x12", 32'(emg[1] - acc[1] + 1), 32'd7);
    chk("stall_lat_0x14", 32'(emg[3] - acc[3] + 1), 32'd7);
    chk("stall_lat_0x15", 32'(emg[4] - acc[4] + 1), 32'd4);
    chk("stall_count", 32'(nv), 32'd8);

    // Reload from D=10 to D=3 mid-stream
    cfg_load = 1'b1; cfg_delay = 5'd10; in_valid = 1'b0;
    step();
    cfg_load = 1'b0;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1; in_data = lanes('h40 + i);
      step();
    end
    cfg_load = 1'b1; cfg_delay = 5'd3; in_valid = 1'b1; in_data = 32'hA5A4A3A2;
    step();
    chk("reload_flush", 32'(out_valid), 32'd0);
    cfg_load = 1'b0;
    nb = busy ? 1 : 0;
    em = -1;
    for (int j = 2; j <= 9; j++) begin
      in_valid = 1'b1; in_data = lanes('h60 + j);
      step();
      if (busy) nb++;
      if (out_valid && out_data == 32'hA5A4A3A2 && em < 0) em = j;
    end
    chk("reload_busy_cycles", 32'(nb), 32'd2);
    chk("reload_emerge_edge", 32'(em), 32'd3);

    // Clamp table: latency of the sample taken on the load edge
    for (int t = 0; t < 8; t++) begin
      in_valid = 1'b0;
      step();
      cfg_load = 1'b1; cfg_delay = tbl[t].cfg; in_valid = 1'b1; in_data = lanes('h90 + t);
      step();
      cfg_load = 1'b0; in_valid = 1'b0;
      lat = out_valid ? 1 : -1;
      for (int j = 2; j <= 40 && lat < 0; j++) begin
        step();
        if (out_valid) lat = j;
      end
      chk($sformatf("clamp_lat_cfg%0d", tbl[t].cfg), 32'(lat), 32'(tbl[t].exp_lat));
    end

    // Async reset while refilling
    cfg_load = 1'b1; cfg_delay = 5'd12; in_valid = 1'b1; in_data = lanes('hC0);
    step();
    cfg_load = 1'b0;
    repeat (3) begin in_data = in_data + 32'h01010101; step(); end
    chk("fill_busy", 32'(busy), 32'd1);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      in_valid = 1'b1; in_data = lanes('h70 + i);
      step();
      if (out_valid && first < 0) first = i;
    end
    chk("arst_default_delay", 32'(first), 32'd10);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      en        = ($urandom_range(3) != 0);
      in_valid  = 1'($urandom_range(1));
      in_data   = $urandom();
      cfg_load  = ($urandom_range(39) == 0);
      cfg_delay = 5'($urandom_range(31));
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
